// File: rtl/bk_save_seq_pkg.sv
// ---------------------------------------------------------------------------
// bk_save_seq_pkg
//   Shared types and constants for the backup-RAM save sequencer.
//   Contents:
//     SECTOR_SHIFT  log2 of the SD sector size in bytes (512-byte sectors)
//     bksv_st_t     sequencer state encoding
//     vol_onehot()  volume number -> per-volume sd_wr request vector
// ---------------------------------------------------------------------------
package bk_save_seq_pkg;

    localparam int SECTOR_SHIFT = 9;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FILL,
        START_WR,
        WAIT_ACK,
        WAIT_DONE
    } bksv_st_t;

    function automatic logic [1:0] vol_onehot(input logic vd);
        return vd ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bk_save_seq_if.sv
// ---------------------------------------------------------------------------
// bk_save_seq_if
//   Handshake bundle between the save sequencer and its two peers: the sdbuf
//   fill engine (toggle handshake) and the HPS SD write path (level handshake).
//   Signals:
//     sd_lba    [31:0]  LBA of the current SD write          (sequencer -> HPS)
//     sd_wr     [1:0]   per-volume SD write request          (sequencer -> HPS)
//     sd_ack    [1:0]   HPS acknowledge                      (HPS -> sequencer)
//     fill_req          toggle: request a sector fill        (sequencer -> sdbuf)
//     fill_ack          toggle: fill done when equal to req  (sdbuf -> sequencer)
//     fill_vd           volume of the requested fill         (sequencer -> sdbuf)
//     fill_lba  [31:0]  sector of the requested fill         (sequencer -> sdbuf)
//   Modports: master = sequencer side, slave = HPS/sdbuf side.
// ---------------------------------------------------------------------------
interface bk_save_seq_if;

    logic [31:0] sd_lba;
    logic [1:0]  sd_wr;
    logic [1:0]  sd_ack;
    logic        fill_req;
    logic        fill_ack;
    logic        fill_vd;
    logic [31:0] fill_lba;

    modport master (
        output sd_lba, sd_wr, fill_req, fill_vd, fill_lba,
        input  sd_ack, fill_ack
    );

    modport slave (
        input  sd_lba, sd_wr, fill_req, fill_vd, fill_lba,
        output sd_ack, fill_ack
    );

endinterface

// File: rtl/bk_save_seq_dirty_map.sv
// ---------------------------------------------------------------------------
// bk_dirty_map
//   Per-volume dirty-sector bitmap of depth N.
//   Ports:
//     clk_sys, reset      system clock, synchronous active-high reset
//     set_en, set_idx     write snoop: mark sector set_idx dirty
//     clr_en, clr_idx     scan: clear sector clr_idx after it was picked up
//     test_idx, test_bit  scan: combinational read of one bit
//     any_dirty           OR of all bits (combinational)
//   A set and a clear of the same bit in one cycle leave the bit set, so a
//   write racing the scan is never lost.
// ---------------------------------------------------------------------------
module bk_dirty_map #(
    parameter int N  = 64,
    parameter int IW = $clog2(N)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic [IW-1:0] test_idx,
    output logic          test_bit,
    output logic          any_dirty
);

    logic [N-1:0] bits;

    // NOTE: the bitmap is flops, not RAM, so it can and must be cleared by
    // reset; a stale dirty bit would trigger a bogus save after reset.
    // NOTE: non-blocking assignments; the set statement comes last so it
    // overrides a clear of the same bit in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bits <= '0;
        end else begin
            if (clr_en) bits[clr_idx] <= 1'b0;
            if (set_en) bits[set_idx] <= 1'b1;
        end
    end

    assign test_bit  = bits[test_idx];
    assign any_dirty = |bits;

endmodule

// File: rtl/bk_save_seq.sv
// ---------------------------------------------------------------------------
// bk_save_seq
//   Backup-RAM save sequencer. Snoops CPU byte writes to internal SRAM
//   (volume 0) and FX-BMP (volume 1), tracks dirty 512-byte sectors, and on a
//   save request walks the dirty sectors: for each one it requests an
//   SDRAM->sdbuf fill, then issues an SD write of that sector to the HPS.
//   Ports:
//     clk_sys, reset             system clock, synchronous active-high reset
//     sram_we, sram_a[14:0]      SRAM byte-write strobe and address
//     bmp_we,  bmp_a[22:0]       FX-BMP byte-write strobe and address
//     img_mounted[1:0]           per-volume image mounted (level)
//     img_sectors0/1[31:0]       image size in sectors per volume
//     bk_save                    save request, rising edge starts a pass
//     bus (bk_save_seq_if.master) fill and SD write handshakes
//     busy                       sequencer not idle (registered)
//     dirty_any                  any tracked sector dirty (registered, 1-cycle lag)
//   Optional feature macro: BK_AUTOSAVE_EN -- when defined, an idle counter
//   starts a save by itself AUTOSAVE_CYC cycles after the last tracked write.
// ---------------------------------------------------------------------------
module bk_save_seq
    import bk_save_seq_pkg::*;
#(
    parameter int          SRAM_SECTORS = 64,
    parameter int          BMP_SECTORS  = 256,
    parameter logic [31:0] AUTOSAVE_CYC = 32'd50_000_000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 sram_we,
    input  logic [14:0]          sram_a,
    input  logic                 bmp_we,
    input  logic [22:0]          bmp_a,
    input  logic [1:0]           img_mounted,
    input  logic [31:0]          img_sectors0,
    input  logic [31:0]          img_sectors1,
    input  logic                 bk_save,
    bk_save_seq_if.master        bus,
    output logic                 busy,
    output logic                 dirty_any
);

    localparam int S0W  = $clog2(SRAM_SECTORS);
    localparam int S1W  = $clog2(BMP_SECTORS);
    localparam int MAXS = (BMP_SECTORS > SRAM_SECTORS) ? BMP_SECTORS : SRAM_SECTORS;
    // One extra code so the index can sit one past the last sector after a
    // WAIT_DONE of the final sector.
    localparam int IW   = $clog2(MAXS + 1);

    bksv_st_t    state;
    logic        vd;
    logic [IW-1:0] idx;
    logic        bk_save_q;
    logic        start_save;

    // -----------------------------------------------------------------------
    // Write snoop: byte address -> sector number; out-of-range BMP writes
    // are dropped.
    // -----------------------------------------------------------------------
    logic [31:0] sram_sec;
    logic [31:0] bmp_sec;
    logic        set0;
    logic        set1;

    assign sram_sec = 32'(sram_a) >> SECTOR_SHIFT;
    assign bmp_sec  = 32'(bmp_a)  >> SECTOR_SHIFT;
    assign set0     = sram_we && (sram_sec < 32'(SRAM_SECTORS));
    assign set1     = bmp_we  && (bmp_sec  < 32'(BMP_SECTORS));

    // -----------------------------------------------------------------------
    // Scan decision for the sector under the index.
    // -----------------------------------------------------------------------
    logic        bit0;
    logic        bit1;
    logic        any0;
    logic        any1;
    logic [31:0] idx32;
    logic [31:0] n_sec;
    logic [31:0] img_n;
    logic        vol_live;
    logic        in_range;
    logic        last;
    logic        cur_bit;
    logic        take;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        idx32    = 32'(idx);
        n_sec    = 32'(SRAM_SECTORS);
        img_n    = img_sectors0;
        cur_bit  = bit0;
        if (vd) begin
            n_sec   = 32'(BMP_SECTORS);
            img_n   = img_sectors1;
            cur_bit = bit1;
        end
        vol_live = img_mounted[vd];
        in_range = idx32 < n_sec;
        last     = idx32 == (n_sec - 32'd1);
        // Sectors beyond the mounted image size are never written.
        take     = (state == SCAN) && vol_live && in_range && cur_bit
                   && (idx32 < img_n);
    end

    bk_dirty_map #(.N(SRAM_SECTORS)) u_map0 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .set_en    (set0),
        .set_idx   (sram_sec[S0W-1:0]),
        .clr_en    (take && !vd),
        .clr_idx   (idx[S0W-1:0]),
        .test_idx  (idx[S0W-1:0]),
        .test_bit  (bit0),
        .any_dirty (any0)
    );

    bk_dirty_map #(.N(BMP_SECTORS)) u_map1 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .set_en    (set1),
        .set_idx   (bmp_sec[S1W-1:0]),
        .clr_en    (take && vd),
        .clr_idx   (idx[S1W-1:0]),
        .test_idx  (idx[S1W-1:0]),
        .test_bit  (bit1),
        .any_dirty (any1)
    );

    // -----------------------------------------------------------------------
    // Save trigger.
    // -----------------------------------------------------------------------
`ifdef BK_AUTOSAVE_EN
    logic [31:0] idle_cnt;
    logic        auto_fire;

    // The counter holds the number of idle edges since the last write; the
    // save is launched on the edge that completes AUTOSAVE_CYC idle cycles.
    assign auto_fire = (state == IDLE) && dirty_any
                       && (idle_cnt >= AUTOSAVE_CYC - 32'd1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (set0 || set1 || auto_fire) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign start_save = (bk_save && !bk_save_q) || auto_fire;
`else
    assign start_save = bk_save && !bk_save_q;
`endif

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            vd           <= 1'b0;
            idx          <= '0;
            bk_save_q    <= 1'b0;
            busy         <= 1'b0;
            dirty_any    <= 1'b0;
            bus.sd_lba   <= '0;
            bus.sd_wr    <= '0;
            bus.fill_req <= 1'b0;
            bus.fill_vd  <= 1'b0;
            bus.fill_lba <= '0;
        end else begin
            bk_save_q <= bk_save;
            dirty_any <= any0 || any1;

            case (state)
                IDLE: begin
                    if (start_save) begin
                        state <= SCAN;
                        vd    <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (take) begin
                        bus.fill_vd  <= vd;
                        bus.fill_lba <= idx32;
                        bus.fill_req <= ~bus.fill_req;
                        state        <= FILL;
                    end else if (!vol_live || !in_range || last) begin
                        // Volume finished (or unmounted): move to the next.
                        if (!vd) begin
                            vd  <= 1'b1;
                            idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                FILL: begin
                    if (bus.fill_ack == bus.fill_req) state <= START_WR;
                end

                START_WR: begin
                    bus.sd_lba <= bus.fill_lba;
                    bus.sd_wr  <= vol_onehot(bus.fill_vd);
                    state      <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (|bus.sd_ack) begin
                        bus.sd_wr <= '0;
                        state     <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.sd_ack == 2'b00) begin
                        idx   <= idx + 1'b1;
                        state <= SCAN;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
